// File: rtl/mod3_tx.sv
`default_nettype none
// ============================================================================
//  Module   : mod3_tx
//  Purpose  : Serial framer: W payload bits MSB first plus 2 check bits that
//             make the whole frame divisible by 3.
//  Revision : 1.0  initial release
// ============================================================================
module mod3_tx #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    input  logic         abort,
    output logic         txd,
    output logic         tx_valid,
    output logic         tx_last,
    output logic [7:0]   frame_cnt
);

    localparam int                 c_CNT_W     = $clog2(W + 2);
    localparam logic [c_CNT_W-1:0] c_LAST_DATA = c_CNT_W'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_DATA  = 2'b01,
        S_CHECK = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W-1:0]       r_shift;
    logic [W-1:0]       w_shift_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [1:0]         r_rem;
    logic [1:0]         w_rem_nxt;
    logic               r_txd;
    logic               w_txd_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_last;
    logic               w_last_nxt;
    logic [7:0]         r_fcnt;
    logic [7:0]         w_fcnt_nxt;
    logic               w_accept;
    logic               w_chk_hi;
    logic               w_chk_lo;

    // One serial step of the remainder: r_next = (2*r + b) mod 3.
    function automatic logic [1:0] f_mod3_step(input logic [1:0] r, input logic b);
        logic [1:0] v;
        case ({r, b})
            3'b000:  v = 2'd0;
            3'b001:  v = 2'd1;
            3'b010:  v = 2'd2;
            3'b011:  v = 2'd0;
            3'b100:  v = 2'd1;
            3'b101:  v = 2'd2;
            default: v = 2'd0;
        endcase
        return v;
    endfunction

    assign in_ready  = ((r_state == S_IDLE) || r_last) && !abort;
    assign w_accept  = in_valid && in_ready;
    assign w_chk_hi  = (r_rem == 2'd1);
    assign w_chk_lo  = (r_rem == 2'd2);

    assign txd       = r_txd;
    assign tx_valid  = r_valid;
    assign tx_last   = r_last;
    assign frame_cnt = r_fcnt;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_rem_nxt   = r_rem;
        w_fcnt_nxt  = r_fcnt;
        w_txd_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;

        if (abort) begin
            w_state_nxt = S_IDLE;
            w_shift_nxt = '0;
            w_cnt_nxt   = '0;
            w_rem_nxt   = 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = S_DATA;
                        w_txd_nxt   = in_data[W-1];
                        w_valid_nxt = 1'b1;
                        w_shift_nxt = {in_data[W-2:0], 1'b0};
                        w_rem_nxt   = f_mod3_step(2'd0, in_data[W-1]);
                        w_cnt_nxt   = '0;
                    end
                end
                S_DATA: begin
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = r_cnt + 1'b1;
                    if (r_cnt == c_LAST_DATA) begin
                        w_state_nxt = S_CHECK;
                        w_txd_nxt   = w_chk_hi;
                    end else begin
                        w_txd_nxt   = r_shift[W-1];
                        w_shift_nxt = {r_shift[W-2:0], 1'b0};
                        w_rem_nxt   = f_mod3_step(r_rem, r_shift[W-1]);
                    end
                end
                S_CHECK: begin
                    if (r_last) begin
                        // Frame completes here; a word accepted now starts the next frame without a gap.
                        w_fcnt_nxt = r_fcnt + 8'd1;
                        if (w_accept) begin
                            w_state_nxt = S_DATA;
                            w_txd_nxt   = in_data[W-1];
                            w_valid_nxt = 1'b1;
                            w_shift_nxt = {in_data[W-2:0], 1'b0};
                            w_rem_nxt   = f_mod3_step(2'd0, in_data[W-1]);
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_shift_nxt = '0;
                            w_cnt_nxt   = '0;
                            w_rem_nxt   = 2'd0;
                        end
                    end else begin
                        w_txd_nxt   = w_chk_lo;
                        w_valid_nxt = 1'b1;
                        w_last_nxt  = 1'b1;
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_rem_nxt   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_rem   <= 2'd0;
            r_txd   <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_fcnt  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rem   <= w_rem_nxt;
            r_txd   <= w_txd_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mod3_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod3_tx
//  Purpose  : Scoreboard bench for mod3_tx: directed frames plus random traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mod3_tx;

    localparam int W = 8;

    logic         clk      = 1'b0;
    logic         rst      = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data  = '0;
    logic         abort    = 1'b0;
    logic         in_ready;
    logic         txd;
    logic         tx_valid;
    logic         tx_last;
    logic [7:0]   frame_cnt;

    int n_chk = 0;
    int n_err = 0;

    logic [W+1:0] exp_q[$];
    int           left  = 0;
    int           sr    = 0;
    logic [7:0]   cnt_m = 8'd0;

    mod3_tx #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .abort     (abort),
        .txd       (txd),
        .tx_valid  (tx_valid),
        .tx_last   (tx_last),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected frame = payload*4 + check, where check brings the value to a multiple of 3.
    function automatic logic [W+1:0] exp_frame(input logic [W-1:0] d);
        longint f;
        f = longint'(d) * 4 + (3 - (longint'(d) % 3)) % 3;
        return f[W+1:0];
    endfunction

    // Stimulus side: record the expected frame for every accepted word.
    always @(negedge clk) begin
        #1;
        if (rst && in_valid && in_ready)
            exp_q.push_back(exp_frame(in_data));
    end

    // Monitor: compares the serial stream against the front of the queue.
    always @(negedge clk) begin
        logic [W+1:0] f;
        if (!rst) begin
            chk("rst_outputs", {txd, tx_valid, tx_last}, 0);
            chk("rst_frame_cnt", frame_cnt, 0);
            left  = 0;
            sr    = 0;
            cnt_m = 8'd0;
            exp_q.delete();
        end else begin
            chk("tx_valid", tx_valid, left > 0);
            chk("tx_last", tx_last, left == 1);
            chk("frame_cnt", frame_cnt, cnt_m);
            chk("in_ready", in_ready, (left <= 1) && !abort);
            if (left > 0) begin
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 0, 1);
                end else begin
                    f = exp_q[0];
                    chk("txd_bit", txd, f[left-1]);
                end
                sr = (2 * sr + int'(txd)) % 3;
            end else begin
                chk("txd_idle", txd, 0);
            end
            if (left == 1 && !abort) begin
                chk("mod3_rem", sr, 0);
                cnt_m = cnt_m + 8'd1;
            end
            if (abort) begin
                if (left > 0 && exp_q.size() > 0) void'(exp_q.pop_front());
                left = 0;
            end else begin
                if (left == 1 && exp_q.size() > 0) void'(exp_q.pop_front());
                if (in_valid && in_ready) begin
                    left = W + 2;
                    sr   = 0;
                end else if (left > 0) begin
                    left--;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [W-1:0] d);
        bit acc;
        int n;
        acc      = 1'b0;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!acc) begin
            @(negedge clk);
            #2;
            acc = in_ready;
            step();
            n++;
            if (!acc && n > 50) begin
                n_chk++;
                n_err++;
                $display("FAIL offer_timeout: word %0h not accepted in %0d cycles", d, n);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        repeat (W + 4) step();
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("ready_after_rst", in_ready, 1);

        // 8'h03 -> 0000_0011_00
        offer(8'h03);
        chk("h03_first_valid", tx_valid, 1);
        chk("h03_first_txd", txd, 0);
        repeat (W + 1) step();
        chk("h03_last", tx_last, 1);
        chk("h03_last_txd", txd, 0);
        step();
        chk("h03_cnt", frame_cnt, 1);
        wait_idle();

        offer(8'h01); wait_idle();
        offer(8'h02); wait_idle();
        offer(8'h05); wait_idle();
        offer(8'hFF); wait_idle();
        chk("single_cnt", frame_cnt, 5);

        // Back-to-back: second word taken on tx_last, no idle gap.
        offer(8'h01);
        offer(8'h02);
        chk("b2b_valid", tx_valid, 1);
        wait_idle();
        chk("b2b_cnt", frame_cnt, 7);

        // Abort on the 4th payload bit.
        offer(8'hA5);
        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid", tx_valid, 0);
        chk("abort_txd", txd, 0);
        chk("abort_cnt", frame_cnt, 7);
        offer(8'h03); wait_idle();
        chk("post_abort_cnt", frame_cnt, 8);

        // Reset asserted during the check bits.
        offer(8'h05);
        repeat (W) step();
        chk("pre_rst_valid", tx_valid, 1);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_out", {txd, tx_valid, tx_last}, 0);
        chk("async_rst_cnt", frame_cnt, 0);
        step(); step();
        rst = 1'b1;
        #1;
        chk("ready_after_rst2", in_ready, 1);
        offer(8'h03); wait_idle();
        chk("post_rst_cnt", frame_cnt, 1);

        // 255 more frames back-to-back wraps the counter to zero.
        for (int i = 0; i < 255; i++) offer(W'($urandom));
        wait_idle();
        chk("wrap_cnt", frame_cnt, 0);

        // Random traffic with occasional aborts.
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = W'($urandom);
            abort    = ($urandom_range(0, 24) == 0);
            step();
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        wait_idle();
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
